// File: rtl/util_tx_timestamp_pkg.sv
// Shared state encoding and default widths for the DAC-side timestamp scheduler.
package util_tx_timestamp_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_CNT_WIDTH  = 16;
  localparam int TS_WIDTH           = 64;
  localparam int LEN_WIDTH          = 32;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT,
    PLAY,
    DROP
  } sched_state_t;

endpackage

// File: rtl/util_sat_counter.sv
// Saturating event counter; a clear wins over a simultaneous increment.
module util_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 dac_clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge dac_clk) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/util_tx_timestamp_sched.sv
// Holds each framed block until the sample timestamp reaches its header, then
// releases it; late blocks are dropped and blocks too far ahead are rejected.
module util_tx_timestamp_sched
  import util_tx_timestamp_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  dac_clk,
  input  logic                  reset,
  input  logic [TS_WIDTH-1:0]   timestamp,
  input  logic [LEN_WIDTH-1:0]  block_len,
  input  logic [LEN_WIDTH-1:0]  max_wait,
  input  logic                  clear_counters,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_xfer_req,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  late_pulse,
  output logic                  early_pulse,
  output logic                  underflow_pulse,
  output logic [CNT_WIDTH-1:0]  late_count,
  output logic [CNT_WIDTH-1:0]  early_count,
  output logic [CNT_WIDTH-1:0]  underflow_count,
  output logic                  busy
);

  sched_state_t         state_reg, state_next;
  logic [TS_WIDTH-1:0]  hdr_reg, hdr_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic [LEN_WIDTH-1:0] word_cnt_reg, word_cnt_next;

  logic                  s_ready_c, m_valid_c;
  logic [DATA_WIDTH-1:0] m_data_c;
  logic                  late_c, early_c, underflow_c;
  logic                  xfer, play_now;
  logic [TS_WIDTH-1:0]   lead;

  assign lead     = hdr_reg - timestamp;
  assign play_now = (state_reg == PLAY) || ((state_reg == WAIT) && (hdr_reg == timestamp));

  always_ff @(posedge dac_clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      hdr_reg      <= '0;
      len_reg      <= '0;
      word_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hdr_reg      <= hdr_next;
      len_reg      <= len_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hdr_next      = hdr_reg;
    len_next      = len_reg;
    word_cnt_next = word_cnt_reg;
    s_ready_c     = 1'b0;
    m_valid_c     = 1'b0;
    m_data_c      = '0;
    late_c        = 1'b0;
    early_c       = 1'b0;
    underflow_c   = 1'b0;
    xfer          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (block_len == '0) begin
          m_valid_c = s_axis_valid;
          m_data_c  = s_axis_data;
          s_ready_c = m_axis_ready;
        end else if (s_axis_xfer_req) begin
          s_ready_c = 1'b1;
          if (s_axis_valid) begin
            hdr_next      = TS_WIDTH'(s_axis_data);
            len_next      = block_len;
            word_cnt_next = '0;
            state_next    = CHECK;
          end
        end
      end
      CHECK: begin
        // Lateness is tested first so late and early can never both fire.
        if (hdr_reg < timestamp) begin
          late_c     = 1'b1;
          state_next = DROP;
        end else if (lead > TS_WIDTH'(max_wait)) begin
          early_c    = 1'b1;
          state_next = DROP;
        end else if (lead == '0) begin
          state_next = PLAY;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT, PLAY: begin
        if (play_now) begin
          m_valid_c   = s_axis_valid;
          m_data_c    = s_axis_data;
          s_ready_c   = m_axis_ready;
          underflow_c = m_axis_ready && !s_axis_valid;
          xfer        = s_axis_valid && m_axis_ready;
          state_next  = PLAY;
        end
      end
      DROP: begin
        s_ready_c = 1'b1;
        xfer      = s_axis_valid;
      end
      default: state_next = IDLE;
    endcase

    if (xfer) begin
      if (word_cnt_reg == len_reg - LEN_WIDTH'(1)) begin
        word_cnt_next = '0;
        state_next    = IDLE;
      end else begin
        word_cnt_next = word_cnt_reg + LEN_WIDTH'(1);
      end
    end

    // Losing the transfer request abandons the block and silences the datapath.
    if ((state_reg != IDLE) && !s_axis_xfer_req) begin
      state_next    = IDLE;
      hdr_next      = '0;
      word_cnt_next = '0;
      s_ready_c     = 1'b0;
      m_valid_c     = 1'b0;
      m_data_c      = '0;
      late_c        = 1'b0;
      early_c       = 1'b0;
      underflow_c   = 1'b0;
    end
  end

  assign s_axis_ready    = s_ready_c & ~reset;
  assign m_axis_valid    = m_valid_c & ~reset;
  assign m_axis_data     = reset ? '0 : m_data_c;
  assign late_pulse      = late_c & ~reset;
  assign early_pulse     = early_c & ~reset;
  assign underflow_pulse = underflow_c & ~reset;
  assign busy            = (state_reg != IDLE);

  logic [2:0]           evt;
  logic [CNT_WIDTH-1:0] cnt_arr [3];

  assign evt = {underflow_pulse, early_pulse, late_pulse};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      util_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
      ) u_cnt (
        .dac_clk (dac_clk),
        .reset   (reset),
        .inc     (evt[gi]),
        .clr     (clear_counters),
        .count   (cnt_arr[gi])
      );
    end
  endgenerate

  assign late_count      = cnt_arr[0];
  assign early_count     = cnt_arr[1];
  assign underflow_count = cnt_arr[2];

endmodule

// File: tb/tb_util_tx_timestamp_sched.sv
// Randomised and directed bench for util_tx_timestamp_sched against a block-level model.
module tb_util_tx_timestamp_sched;

  logic        dac_clk = 1'b0;
  logic        reset;
  logic [63:0] timestamp;
  logic [31:0] block_len, max_wait;
  logic        clear_counters;
  logic        s_axis_valid, s_axis_ready, s_axis_xfer_req;
  logic [63:0] s_axis_data, m_axis_data;
  logic        m_axis_valid, m_axis_ready;
  logic        late_pulse, early_pulse, underflow_pulse, busy;
  logic [15:0] late_count, early_count, underflow_count;

  always #5 dac_clk = ~dac_clk;

  util_tx_timestamp_sched #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .dac_clk(dac_clk), .reset(reset), .timestamp(timestamp),
    .block_len(block_len), .max_wait(max_wait), .clear_counters(clear_counters),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_xfer_req(s_axis_xfer_req), .s_axis_data(s_axis_data),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready), .m_axis_data(m_axis_data),
    .late_pulse(late_pulse), .early_pulse(early_pulse), .underflow_pulse(underflow_pulse),
    .late_count(late_count), .early_count(early_count), .underflow_count(underflow_count),
    .busy(busy)
  );

  // Source words; a header carries an offset applied to the timestamp when presented.
  typedef struct {
    bit          is_hdr;
    longint      off;
    logic [63:0] val;
  } item_t;

  item_t  src_q[$];
  int     bubble_cnt = 0;
  int     ready_mode = 0;   // 0: sink always ready, 1: ready follows valid, 2: random
  bit     rand_mode  = 0;
  int     checks = 0, errors = 0;
  longint cyc = 0;

  // Block-level model: is a block open, has its one-cycle verdict happened, is it discarded.
  bit          blk_open = 0, judged = 0, dropping = 0;
  logic [63:0] hdr_m = '0;
  longint      left_m = 0;
  int          cnt_late = 0, cnt_early = 0, cnt_under = 0;

  int     dut_xfers = 0;
  longint hdr_acc_cyc = 0, first_out_cyc = -1, last_out_cyc = -1;

  function automatic item_t mk_data(input logic [63:0] v);
    item_t it;
    it.is_hdr = 1'b0; it.off = 0; it.val = v;
    return it;
  endfunction

  function automatic item_t mk_hdr(input longint off);
    item_t it;
    it.is_hdr = 1'b1; it.off = off; it.val = '0;
    return it;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_block(input longint off, input int n);
    src_q.push_back(mk_hdr(off));
    for (int i = 0; i < n; i++) src_q.push_back(mk_data({$urandom, $urandom}));
  endtask

  task automatic drive();
    if (rand_mode) begin
      s_axis_xfer_req = ($urandom_range(0, 59) != 0);
      clear_counters  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) block_len = $urandom_range(0, 5);
      if (bubble_cnt == 0 && $urandom_range(0, 7) == 0) bubble_cnt = 1;
    end
    if (bubble_cnt > 0 || src_q.size() == 0) begin
      s_axis_valid = 1'b0;
      s_axis_data  = '0;
      if (bubble_cnt > 0) bubble_cnt--;
    end else begin
      s_axis_valid = 1'b1;
      s_axis_data  = src_q[0].is_hdr ? timestamp + 64'(src_q[0].off) : src_q[0].val;
    end
    case (ready_mode)
      0:       m_axis_ready = 1'b1;
      1:       m_axis_ready = s_axis_valid;
      default: m_axis_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic model_and_check();
    bit          e_ready, e_valid, e_late, e_early, e_under;
    logic [63:0] e_data;
    e_ready = 0; e_valid = 0; e_late = 0; e_early = 0; e_under = 0; e_data = '0;

    if (!reset) begin
      if (!blk_open) begin
        if (block_len == 0) begin
          e_valid = s_axis_valid; e_data = s_axis_data; e_ready = m_axis_ready;
        end else if (s_axis_xfer_req) begin
          e_ready = 1;
        end
      end else if (!s_axis_xfer_req) begin
        // abandoned block: nothing moves
      end else if (!judged) begin
        if (hdr_m < timestamp) e_late = 1;
        else if (hdr_m - timestamp > 64'(max_wait)) e_early = 1;
      end else if (dropping) begin
        e_ready = 1;
      end else if (timestamp >= hdr_m) begin
        e_valid = s_axis_valid; e_data = s_axis_data; e_ready = m_axis_ready;
        e_under = m_axis_ready && !s_axis_valid;
      end
    end

    check("s_axis_ready", s_axis_ready, e_ready);
    check("m_axis_valid", m_axis_valid, e_valid);
    if (e_valid || reset) check("m_axis_data", m_axis_data, e_data);
    check("late_pulse", late_pulse, e_late);
    check("early_pulse", early_pulse, e_early);
    check("underflow_pulse", underflow_pulse, e_under);
    if (!(reset && cyc == 0)) begin
      check("busy", busy, blk_open);
      check("late_count", late_count, 64'(cnt_late));
      check("early_count", early_count, 64'(cnt_early));
      check("underflow_count", underflow_count, 64'(cnt_under));
    end

    if (!reset && m_axis_valid && m_axis_ready) begin
      dut_xfers++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end

    if (!reset && s_axis_valid && e_ready && src_q.size() > 0) void'(src_q.pop_front());

    if (reset) begin
      blk_open = 0; cnt_late = 0; cnt_early = 0; cnt_under = 0;
    end else begin
      if (!blk_open) begin
        if (block_len != 0 && s_axis_xfer_req && s_axis_valid) begin
          blk_open = 1; judged = 0; dropping = 0;
          hdr_m = s_axis_data; left_m = longint'(block_len);
          hdr_acc_cyc = cyc; first_out_cyc = -1;
        end
      end else if (!s_axis_xfer_req) begin
        blk_open = 0;
      end else if (!judged) begin
        judged = 1; dropping = e_late || e_early;
      end else if (e_ready && s_axis_valid) begin
        left_m--;
        if (left_m == 0) blk_open = 0;
      end
      if (clear_counters) begin
        cnt_late = 0; cnt_early = 0; cnt_under = 0;
      end else begin
        if (e_late  && cnt_late  < 65535) cnt_late++;
        if (e_early && cnt_early < 65535) cnt_early++;
        if (e_under && cnt_under < 65535) cnt_under++;
      end
    end
  endtask

  task automatic tick();
    drive();
    @(negedge dac_clk);
    model_and_check();
    @(posedge dac_clk);
    #1;
    timestamp = timestamp + 64'd1;   // the DAC consumes one sample per clock
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_q.size() != 0 || blk_open) && n < budget) begin
      if (src_q.size() == 0) src_q.push_back(mk_data({$urandom, $urandom}));
      tick();
      n++;
    end
    checks++;
    if (src_q.size() != 0 || blk_open) begin
      errors++;
      $display("FAIL drain_timeout at cycle %0d: queue %0d open %0d, expected both 0",
               cyc, src_q.size(), blk_open);
    end
  endtask

  task automatic report(input string name);
    $display("scenario %s: words_out=%0d late=%0d early=%0d underflow=%0d",
             name, dut_xfers, late_count, early_count, underflow_count);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1; timestamp = 64'h1000_0000; block_len = 0; max_wait = 0;
    clear_counters = 0; s_axis_xfer_req = 1; s_axis_valid = 0; s_axis_data = '0;
    m_axis_ready = 0;

    // Passthrough, including words offered while still in reset.
    ready_mode = 1;
    for (int i = 1; i <= 8; i++) src_q.push_back(mk_data(64'(i)));
    repeat (3) tick();
    reset = 0;
    dut_xfers = 0;
    drain(100);
    check("pt_words_out", 64'(dut_xfers), 64'd8);
    report("passthrough");

    // Header one ahead: straight from the verdict cycle into playback.
    ready_mode = 0; block_len = 4; max_wait = 100; dut_xfers = 0;
    push_block(1, 4);
    drain(100);
    check("direct_first_gap", 64'(first_out_cyc - hdr_acc_cyc), 64'd2);
    check("direct_burst_span", 64'(last_out_cyc - first_out_cyc), 64'd3);
    check("direct_words_out", 64'(dut_xfers), 64'd4);
    report("direct_play");

    // Header five ahead: held until the timestamp matches.
    dut_xfers = 0;
    push_block(5, 4);
    drain(100);
    check("wait_first_gap", 64'(first_out_cyc - hdr_acc_cyc), 64'd5);
    check("wait_words_out", 64'(dut_xfers), 64'd4);
    report("wait_play");

    // Late block.
    dut_xfers = 0;
    push_block(-10, 4);
    drain(100);
    check("late_words_out", 64'(dut_xfers), 64'd0);
    check("late_count_lit", 64'(late_count), 64'd1);
    report("late_drop");

    // Early block.
    push_block(200, 4);
    drain(100);
    check("early_words_out", 64'(dut_xfers), 64'd0);
    check("early_count_lit", 64'(early_count), 64'd1);
    report("early_drop");

    // Three-cycle starvation mid-block.
    push_block(1, 4);
    n = 0;
    while (src_q.size() > 3 && n < 50) begin tick(); n++; end
    check("underflow_reached_play", 64'(src_q.size() <= 3), 64'd1);
    bubble_cnt = 3;
    drain(100);
    check("underflow_count_lit", 64'(underflow_count), 64'd3);
    check("underflow_words_out", 64'(dut_xfers), 64'd4);
    report("underflow");
    clear_counters = 1; tick(); clear_counters = 0; tick();
    check("clr_late", 64'(late_count), 64'd0);
    check("clr_early", 64'(early_count), 64'd0);
    check("clr_underflow", 64'(underflow_count), 64'd0);

    // Abort while waiting, then a fresh block.
    src_q.push_back(mk_hdr(20));
    repeat (5) tick();
    check("abort_wait_busy_before", 64'(busy), 64'd1);
    s_axis_xfer_req = 0; tick(); s_axis_xfer_req = 1;
    check("abort_wait_busy_after", 64'(busy), 64'd0);
    dut_xfers = 0;
    push_block(3, 4);
    drain(100);
    check("after_abort_wait_words", 64'(dut_xfers), 64'd4);
    report("abort_wait");

    // Abort mid-playback, then a fresh block.
    dut_xfers = 0;
    push_block(1, 4);
    n = 0;
    while (dut_xfers < 2 && n < 50) begin tick(); n++; end
    check("abort_play_reached", 64'(dut_xfers), 64'd2);
    src_q.delete();
    s_axis_xfer_req = 0; tick(); s_axis_xfer_req = 1;
    check("abort_play_busy_after", 64'(busy), 64'd0);
    dut_xfers = 0;
    push_block(2, 4);
    drain(100);
    check("after_abort_play_words", 64'(dut_xfers), 64'd4);
    report("abort_play");

    // Randomised traffic against the model.
    rand_mode = 1; ready_mode = 2;
    for (int b = 0; b < 30; b++) begin
      block_len = $urandom_range(0, 5);
      max_wait  = $urandom_range(0, 30);
      dut_xfers = 0;
      for (int k = 0; k < 3; k++)
        push_block(longint'($urandom_range(0, 45)) - 5, (block_len == 0) ? 3 : int'(block_len));
      drain(3000);
      report($sformatf("random_%0d", b));
    end
    rand_mode = 0; s_axis_xfer_req = 1; clear_counters = 0; ready_mode = 0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
